// File: rtl/div_issue_ctrl_pkg.sv
// Shared encodings for the divider handshake and the EX-stage divide controller.
package div_issue_ctrl_pkg;

    typedef enum logic [1:0] {
        DivFree   = 2'b00,
        DivByZero = 2'b01,
        DivOn     = 2'b10,
        DivEnd    = 2'b11
    } div_state_e;

    localparam logic DivStart = 1'b1;
    localparam logic DivStop  = 1'b0;

    typedef enum logic {
        DivCtrlIdle = 1'b0,
        DivCtrlBusy = 1'b1
    } div_ctrl_state_e;

endpackage

// File: rtl/div_issue_ctrl.sv
// EX-stage divide issue/stall controller; owns the architectural HI/LO registers.
module div_issue_ctrl
    import div_issue_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_div_valid_i,
    input  logic        ex_signed_i,
    input  logic [31:0] ex_op1_i,
    input  logic [31:0] ex_op2_i,
    input  logic        flush_i,
    input  logic        wb_hi_we_i,
    input  logic        wb_lo_we_i,
    input  logic [31:0] wb_data_i,
    input  logic [1:0]  div_state_i,
    input  logic        div_ready_i,
    input  logic [63:0] div_result_i,
    output logic        div_start_o,
    output logic        div_annul_o,
    output logic        div_signed_o,
    output logic [31:0] div_op1_o,
    output logic [31:0] div_op2_o,
    output logic        stall_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    div_ctrl_state_e state_q, state_d;
    logic [31:0]     op1_q, op2_q;
    logic            signed_q;
    logic [31:0]     hi_q, lo_q;
    logic            issue, commit;

    always_comb begin
        state_d      = state_q;
        div_start_o  = DivStop;
        div_annul_o  = flush_i;
        stall_o      = 1'b0;
        div_signed_o = ex_signed_i;
        div_op1_o    = ex_op1_i;
        div_op2_o    = ex_op2_i;
        issue        = 1'b0;
        commit       = 1'b0;
        case (state_q)
            DivCtrlIdle: begin
                if (ex_div_valid_i && !flush_i) begin
                    stall_o = 1'b1;
                    if (div_state_i == DivFree) begin
                        div_start_o = DivStart;
                        issue       = 1'b1;
                        state_d     = DivCtrlBusy;
                    end
                end
            end
            DivCtrlBusy: begin
                div_signed_o = signed_q;
                div_op1_o    = op1_q;
                div_op2_o    = op2_q;
                stall_o      = !div_ready_i;
                // Dropping start in the ready cycle lets the divider reach DivFree on the commit edge.
                if (flush_i) begin
                    state_d = DivCtrlIdle;
                end else if (div_ready_i) begin
                    commit  = 1'b1;
                    state_d = DivCtrlIdle;
                end else begin
                    div_start_o = DivStart;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= DivCtrlIdle;
            op1_q    <= '0;
            op2_q    <= '0;
            signed_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q <= state_d;
            if (issue) begin
                op1_q    <= ex_op1_i;
                op2_q    <= ex_op2_i;
                signed_q <= ex_signed_i;
            end
            // The WB instruction is older than the divide, so the divide result wins.
            if (commit) begin
                hi_q <= div_result_i[63:32];
                lo_q <= div_result_i[31:0];
            end else begin
                if (wb_hi_we_i) hi_q <= wb_data_i;
                if (wb_lo_we_i) lo_q <= wb_data_i;
            end
        end
    end

    assign hi_o = hi_q;
    assign lo_o = lo_q;

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Bench for div_issue_ctrl: behavioural iterative divider plus directed divide vectors and corner sequences.
module tb_div_issue_ctrl;
    import div_issue_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_div_valid_i;
    logic        ex_signed_i;
    logic [31:0] ex_op1_i;
    logic [31:0] ex_op2_i;
    logic        flush_i;
    logic        wb_hi_we_i;
    logic        wb_lo_we_i;
    logic [31:0] wb_data_i;
    logic [1:0]  div_state_i;
    logic        div_ready_i;
    logic [63:0] div_result_i;
    logic        div_start_o;
    logic        div_annul_o;
    logic        div_signed_o;
    logic [31:0] div_op1_o;
    logic [31:0] div_op2_o;
    logic        stall_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int total = 0;
    int bad   = 0;

    div_issue_ctrl dut (
        .clk(clk), .rst(rst),
        .ex_div_valid_i(ex_div_valid_i), .ex_signed_i(ex_signed_i),
        .ex_op1_i(ex_op1_i), .ex_op2_i(ex_op2_i), .flush_i(flush_i),
        .wb_hi_we_i(wb_hi_we_i), .wb_lo_we_i(wb_lo_we_i), .wb_data_i(wb_data_i),
        .div_state_i(div_state_i), .div_ready_i(div_ready_i), .div_result_i(div_result_i),
        .div_start_o(div_start_o), .div_annul_o(div_annul_o), .div_signed_o(div_signed_o),
        .div_op1_o(div_op1_o), .div_op2_o(div_op2_o), .stall_o(stall_o),
        .hi_o(hi_o), .lo_o(lo_o)
    );

    always #5 clk = ~clk;

    // Divider model: On for 32 iterations, finalize, registered ready; annul aborts only in On.
    div_state_e  dv_state;
    logic [5:0]  dv_cnt;

    function automatic logic [63:0] ref_div(input logic s, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa, sb, sq, sr;
        logic [31:0] uq, ur;
        sa = a; sb = b;
        if (s) begin
            sq = sa / sb;
            sr = sa % sb;
            return {sr, sq};
        end
        uq = a / b;
        ur = a % b;
        return {ur, uq};
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            dv_state     <= DivFree;
            dv_cnt       <= '0;
            div_ready_i  <= 1'b0;
            div_result_i <= '0;
        end else begin
            case (dv_state)
                DivFree: begin
                    div_ready_i <= 1'b0;
                    if (div_start_o == DivStart && !div_annul_o) begin
                        if (div_op2_o == 32'd0) dv_state <= DivByZero;
                        else begin
                            dv_state <= DivOn;
                            dv_cnt   <= '0;
                        end
                    end
                end
                DivByZero: begin
                    div_result_i <= '0;
                    dv_state     <= DivEnd;
                end
                DivOn: begin
                    if (div_annul_o) dv_state <= DivFree;
                    else if (dv_cnt != 6'd32) dv_cnt <= dv_cnt + 6'd1;
                    else begin
                        div_result_i <= ref_div(div_signed_o, div_op1_o, div_op2_o);
                        dv_state     <= DivEnd;
                    end
                end
                DivEnd: begin
                    if (div_start_o == DivStop) begin
                        dv_state    <= DivFree;
                        div_ready_i <= 1'b0;
                    end else begin
                        div_ready_i <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign div_state_i = dv_state;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents a divide in the current cycle, counts stall cycles, then checks HI/LO after commit.
    task automatic run_div(input string name, input logic s, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] eh, input logic [31:0] el, input int unsigned es);
        int unsigned n;
        ex_div_valid_i = 1'b1;
        ex_signed_i    = s;
        ex_op1_i       = a;
        ex_op2_i       = b;
        @(negedge clk);
        check({name, ".issue_start"}, {31'd0, div_start_o}, 32'd1);
        n = 0;
        while (stall_o === 1'b1 && n < 100) begin
            n++;
            @(negedge clk);
        end
        check({name, ".stall_cycles"}, n, es);
        step();
        ex_div_valid_i = 1'b0;
        check({name, ".hi"}, hi_o, eh);
        check({name, ".lo"}, lo_o, el);
    endtask

    typedef struct {
        string       name;
        logic        sgn;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int unsigned exp_stall;
    } vec_t;

    vec_t vecs[6];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{"div_neg7_2",  1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 35};
        vecs[1] = '{"divu_big_2",  1'b0, 32'hFFFF_FFF9, 32'd2, 32'h0000_0001, 32'h7FFF_FFFC, 35};
        vecs[2] = '{"div_by_zero", 1'b1, 32'd5,         32'd0, 32'h0000_0000, 32'h0000_0000, 3};
        vecs[3] = '{"div_100_7",   1'b1, 32'd100,       32'd7, 32'd2,         32'd14,        35};
        vecs[4] = '{"div_7_neg2",  1'b1, 32'd7, 32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 35};
        vecs[5] = '{"divu_zero",   1'b0, 32'd9,         32'd0, 32'h0000_0000, 32'h0000_0000, 3};

        rst = 1'b1;
        ex_div_valid_i = 1'b0; ex_signed_i = 1'b0; ex_op1_i = '0; ex_op2_i = '0;
        flush_i = 1'b0; wb_hi_we_i = 1'b0; wb_lo_we_i = 1'b0; wb_data_i = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset.hi", hi_o, 32'd0);
        check("reset.lo", lo_o, 32'd0);
        check("reset.stall", {31'd0, stall_o}, 32'd0);
        check("reset.start", {31'd0, div_start_o}, 32'd0);
        step();

        // Consecutive vectors issue in the cycle right after each commit.
        for (int i = 0; i < 6; i++)
            run_div(vecs[i].name, vecs[i].sgn, vecs[i].op1, vecs[i].op2,
                    vecs[i].exp_hi, vecs[i].exp_lo, vecs[i].exp_stall);

        // MTHI/MTLO in idle, then flush at C10 of DIV 100/7.
        wb_hi_we_i = 1'b1; wb_data_i = 32'h11;
        step();
        wb_hi_we_i = 1'b0; wb_lo_we_i = 1'b1; wb_data_i = 32'h22;
        step();
        wb_lo_we_i = 1'b0;
        check("mthi_idle", hi_o, 32'h11);
        check("mtlo_idle", lo_o, 32'h22);
        ex_div_valid_i = 1'b1; ex_signed_i = 1'b1; ex_op1_i = 32'd100; ex_op2_i = 32'd7;
        repeat (10) step();
        flush_i = 1'b1;
        @(negedge clk);
        check("flush.annul", {31'd0, div_annul_o}, 32'd1);
        check("flush.start", {31'd0, div_start_o}, 32'd0);
        step();
        flush_i = 1'b0;
        check("flush.hi_kept", hi_o, 32'h11);
        check("flush.lo_kept", lo_o, 32'h22);
        run_div("divu_after_flush", 1'b0, 32'd100, 32'd7, 32'd2, 32'd14, 35);

        // MTLO while busy, MTHI colliding with the commit of DIV 10/7.
        ex_div_valid_i = 1'b1; ex_signed_i = 1'b1; ex_op1_i = 32'd10; ex_op2_i = 32'd7;
        repeat (5) step();
        wb_lo_we_i = 1'b1; wb_data_i = 32'h1234;
        step();
        wb_lo_we_i = 1'b0;
        check("mtlo_busy", lo_o, 32'h1234);
        repeat (29) step();
        wb_hi_we_i = 1'b1; wb_data_i = 32'hAAAA_0000;
        @(negedge clk);
        check("collide.stall_low", {31'd0, stall_o}, 32'd0);
        step();
        wb_hi_we_i = 1'b0; ex_div_valid_i = 1'b0;
        check("collide.hi", hi_o, 32'd3);
        check("collide.lo", lo_o, 32'd1);

        // Flush during ByZero: next divide waits while the divider drains End.
        ex_div_valid_i = 1'b1; ex_signed_i = 1'b1; ex_op1_i = 32'd5; ex_op2_i = 32'd0;
        step();
        flush_i = 1'b1;
        @(negedge clk);
        check("zflush.annul", {31'd0, div_annul_o}, 32'd1);
        step();
        flush_i = 1'b0; ex_op1_i = 32'd20; ex_op2_i = 32'd3;
        @(negedge clk);
        check("zflush.wait_stall", {31'd0, stall_o}, 32'd1);
        check("zflush.wait_start", {31'd0, div_start_o}, 32'd0);
        step();
        check("zflush.hi_kept", hi_o, 32'd3);
        check("zflush.lo_kept", lo_o, 32'd1);
        run_div("div_after_zflush", 1'b1, 32'd20, 32'd3, 32'd2, 32'd6, 35);

        // Asynchronous reset in the middle of a divide.
        ex_div_valid_i = 1'b1; ex_signed_i = 1'b1; ex_op1_i = 32'd100; ex_op2_i = 32'd7;
        repeat (5) step();
        #1;
        rst = 1'b1; ex_div_valid_i = 1'b0;
        #1;
        check("areset.hi", hi_o, 32'd0);
        check("areset.lo", lo_o, 32'd0);
        check("areset.stall", {31'd0, stall_o}, 32'd0);
        step();
        rst = 1'b0;
        step();
        run_div("div_after_reset", 1'b1, 32'd9, 32'd3, 32'd0, 32'd3, 35);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/div_issue_ctrl.md
# div_issue_ctrl

EX-stage control block for the iterative divider. It accepts DIV/DIVU from the EX stage and issues them to the divider with the start/stop/annul handshake. It stalls the pipeline until the 64-bit result returns, then commits the quotient and remainder to the architectural HI/LO registers, which it owns. MTHI/MTLO writes from WB also land here.

## Interface
Parameters: none. Shared constants come from `defines.vh`: DivFree, DivByZero, DivOn, DivEnd, DivStart, DivStop.

Ports:
- clk  in  1  sole clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- ex_div_valid_i  in  1  DIV/DIVU currently in EX
- ex_signed_i  in  1  1 = DIV, 0 = DIVU
- ex_op1_i  in  32  dividend (rs)
- ex_op2_i  in  32  divisor (rt)
- flush_i  in  1  kill the EX instruction / in-flight divide
- wb_hi_we_i  in  1  MTHI commit
- wb_lo_we_i  in  1  MTLO commit
- wb_data_i  in  32  MTHI/MTLO data
- div_state_i  in  2  divider FSM state
- div_ready_i  in  1  divider result valid
- div_result_i  in  64  {remainder, quotient}
- div_start_o  out  1  DivStart/DivStop to divider
- div_annul_o  out  1  annul to divider
- div_signed_o  out  1  signed select to divider
- div_op1_o  out  32  dividend to divider
- div_op2_o  out  32  divisor to divider
- stall_o  out  1  freeze IF..EX
- hi_o  out  32  architectural HI
- lo_o  out  32  architectural LO

## Operation
The controller is a two-state FSM: IDLE and BUSY. Reset (async) puts it in IDLE and clears hi_o, lo_o, and the latched operands and sign bit to 0.

IDLE:
- Divider operands and sign pass straight through from EX.
- Issue condition: ex_div_valid_i & !flush_i & div_state_i==DivFree.
- On issue: div_start_o=DivStart, stall_o=1. Latch op1, op2 and signed. Go to BUSY.
- If ex_div_valid_i & !flush_i but the divider is not free: stall_o=1, start=DivStop, remain in IDLE.

BUSY:
- Operands are driven from the latches.
- div_start_o=DivStart while !div_ready_i.
- stall_o = !div_ready_i.
- When div_ready_i=1:
  - start drops to DivStop in the same cycle (combinational), so the divider returns to DivFree on the same edge.
  - At that edge: hi_o<=div_result_i[63:32], lo_o<=div_result_i[31:0]. Go to IDLE.
- flush_i in BUSY: div_annul_o=1, start=DivStop, go to IDLE, no HI/LO write. This overrides ready in the same cycle.

Fixed rules:
- div_annul_o = flush_i in both states.
- HI/LO write priority: a divide commit overrides a same-cycle MTHI/MTLO, because the WB instruction is older.
- MTHI/MTLO apply in any state when no divide commit occurs that cycle.

## Timing
Cycle C0 is the issue cycle.

Nonzero divisor:
- Divider goes On at edge0 and runs iterations at edges 1–32.
- Finalize at edge33; ready registered at edge34.
- div_ready_i is seen in C35.
- stall_o is high C0–C34 and low in C35. HI/LO update at the end of C35. Total 36 cycles.

Zero divisor:
- Divider path: ByZero, then End, then ready.
- div_ready_i is seen in C3. HI=LO=0 written at the end of C3.
- stall_o is high C0–C2.

Back-to-back divides:
- A second divide may present in C36 (the cycle after commit). The divider is DivFree then, so it issues at once.

After a flush:
- The divider may spend up to 2 cycles in ByZero/End.
- A new divide in that window waits in IDLE with stall_o=1 until div_state_i==DivFree. Stale End results are never consumed.

Reset mid-divide: the controller returns to IDLE immediately and HI/LO clear. The divider shares rst.

## Structure
- Divider FSM encodings and DivStart/DivStop are taken from `defines.vh`. Add DivCtrlIdle and DivCtrlBusy there.
- Single module, no sub-module. HI/LO registers live inline.

## Test plan
- Signed divide, normal: DIV op1=-7 (0xFFFFFFF9), op2=2 → stall 35 cycles, then LO=0xFFFFFFFD (-3) and HI=0xFFFFFFFF (-1).
- Unsigned divide: DIVU op1=0xFFFFFFF9, op2=2 → LO=0x7FFFFFFC, HI=1.
- Divide by zero: DIV op1=5, op2=0 → stall 3 cycles, then HI=LO=0.
- Flush mid-divide: flush_i at C10 of DIV 100/7 → annul pulse, HI/LO keep prior values. An immediate DIVU 100/7 then yields LO=14, HI=2.
- Write collision: MTHI 0xAAAA0000 in the same cycle as a DIV commit with result HI=3 → HI=3. MTLO 0x1234 while BUSY → LO=0x1234, later overwritten by the divide commit.
- Reset: async rst asserted mid-divide → hi_o=lo_o=0 and stall_o=0 without waiting for a clock edge. The next DIV 9/3 gives LO=3, HI=0.
